// File: rtl/vga_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : vga_mem_arbiter
//  Purpose  : Shares one single-port synchronous frame-buffer RAM (1-cycle
//             read latency) between the VGA display fetch and a host port.
//             Display slots (pix_en with xc<640, yc<480) always own the RAM.
//             A host request is issued in the first non-display cycle while
//             the host FSM is in ISSUE.
//  Ports    : clk, reset (async, active-high)
//             pix_en, xc, yc          : pixel tick and beam position
//             host_req/we/addr/wdata  : host request (level, held until ack)
//             host_ack, host_rdata    : one-cycle completion, read data
//             mem_addr/we/wdata       : RAM command (combinational, same cycle)
//             mem_rdata               : RAM data for last cycle's address
//             pix_data, pix_valid     : registered display pixel
//  Config   : `define VGA_ARB_HOST_READ_EN enables host reads through the
//             RDWAIT state. Without it, host reads are acked with data 0 and
//             never touch the RAM. The port list is the same in both builds.
//  Revision : 1.0  initial release
// ============================================================================
module vga_mem_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  input  logic [9:0]  xc,
  input  logic [9:0]  yc,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [18:0] host_addr,
  input  logic [7:0]  host_wdata,
  output logic        host_ack,
  output logic [7:0]  host_rdata,
  output logic [18:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  pix_data,
  output logic        pix_valid
);

  localparam logic [9:0]  H_VISIBLE = 10'd640;
  localparam logic [9:0]  V_VISIBLE = 10'd480;
  localparam logic [18:0] FB_PIXELS = 19'd307200;

`ifdef VGA_ARB_HOST_READ_EN
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_RDWAIT = 2'd2,
    S_ACK    = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_ACK    = 2'd3
  } state_t;
`endif

  state_t      state_q, state_d;
  logic        host_ack_q, host_ack_d;
  logic [7:0]  pix_data_q, pix_data_d;
  logic        pix_valid_q, pix_valid_d;
  logic        slot_q, slot_d;       // previous cycle was a display slot
  logic        blank_q, blank_d;     // previous cycle was a non-visible tick
  logic [18:0] addr_hold_q, addr_hold_d;
`ifdef VGA_ARB_HOST_READ_EN
  logic [7:0]  host_rdata_q, host_rdata_d;
`endif

  logic        disp_slot;
  logic [18:0] disp_addr;
  logic        host_in_range;
  logic        host_touch;           // this host request really uses the RAM
  logic        host_go;              // host access is issued this cycle
  logic [18:0] mem_addr_c;
  logic        mem_we_c;
  logic [7:0]  mem_wdata_c;

  always_comb begin
    disp_slot     = pix_en && (xc < H_VISIBLE) && (yc < V_VISIBLE);
    // yc*640 + xc as (yc*512) + (yc*128) + xc
    disp_addr     = {yc, 9'd0} + {2'd0, yc, 7'd0} + {9'd0, xc};
    host_in_range = host_addr < FB_PIXELS;
`ifdef VGA_ARB_HOST_READ_EN
    host_touch    = host_in_range;
`else
    host_touch    = host_in_range && host_we;
`endif
    host_go       = (state_q == S_ISSUE) && host_req && !disp_slot;

    // RAM port: display first, then host; otherwise the address is parked
    mem_addr_c  = addr_hold_q;
    mem_we_c    = 1'b0;
    mem_wdata_c = 8'h00;
    addr_hold_d = addr_hold_q;
    if (disp_slot) begin
      mem_addr_c  = disp_addr;
      addr_hold_d = disp_addr;
    end else if (host_go && host_touch) begin
      mem_addr_c  = host_addr;
      mem_we_c    = host_we;
      mem_wdata_c = host_wdata;
      addr_hold_d = host_addr;
    end

    // Display pipeline: RAM data for a slot arrives one cycle later
    slot_d      = disp_slot;
    blank_d     = pix_en && !disp_slot;
    pix_data_d  = pix_data_q;
    pix_valid_d = pix_valid_q;
    if (slot_q) begin
      pix_data_d  = mem_rdata;
      pix_valid_d = 1'b1;
    end else if (blank_q) begin
      pix_data_d  = 8'h00;
      pix_valid_d = 1'b0;
    end

    // Host FSM
    state_d = state_q;
`ifdef VGA_ARB_HOST_READ_EN
    host_rdata_d = host_rdata_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (host_req) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        // A dropped request is abandoned so the FSM cannot get stuck
        if (!host_req) begin
          state_d = S_IDLE;
        end else if (!disp_slot) begin
`ifdef VGA_ARB_HOST_READ_EN
          state_d = host_we ? S_ACK : S_RDWAIT;
`else
          state_d = S_ACK;
`endif
        end
      end
`ifdef VGA_ARB_HOST_READ_EN
      S_RDWAIT: begin
        // Out-of-range reads never touched the RAM and return zero
        host_rdata_d = host_in_range ? mem_rdata : 8'h00;
        state_d      = S_ACK;
      end
`endif
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    host_ack_d = (state_d == S_ACK);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      host_ack_q   <= 1'b0;
      pix_data_q   <= 8'h00;
      pix_valid_q  <= 1'b0;
      slot_q       <= 1'b0;
      blank_q      <= 1'b0;
      addr_hold_q  <= 19'd0;
`ifdef VGA_ARB_HOST_READ_EN
      host_rdata_q <= 8'h00;
`endif
    end else begin
      state_q      <= state_d;
      host_ack_q   <= host_ack_d;
      pix_data_q   <= pix_data_d;
      pix_valid_q  <= pix_valid_d;
      slot_q       <= slot_d;
      blank_q      <= blank_d;
      addr_hold_q  <= addr_hold_d;
`ifdef VGA_ARB_HOST_READ_EN
      host_rdata_q <= host_rdata_d;
`endif
    end
  end

  // The RAM command is combinational, so it is forced idle while in reset
  assign mem_addr  = reset ? 19'd0 : mem_addr_c;
  assign mem_we    = reset ? 1'b0  : mem_we_c;
  assign mem_wdata = reset ? 8'h00 : mem_wdata_c;
  assign host_ack  = host_ack_q;
  assign pix_data  = pix_data_q;
  assign pix_valid = pix_valid_q;
`ifdef VGA_ARB_HOST_READ_EN
  assign host_rdata = host_rdata_q;
`else
  assign host_rdata = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_mem_arbiter
//  Purpose  : Directed self-checking bench for vga_mem_arbiter with a
//             behavioural single-port synchronous RAM.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_vga_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_en;
  logic [9:0]  xc, yc;
  logic        host_req, host_we;
  logic [18:0] host_addr;
  logic [7:0]  host_wdata;
  logic        host_ack;
  logic [7:0]  host_rdata;
  logic [18:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [7:0]  pix_data;
  logic        pix_valid;

  int n_checks = 0;
  int n_pass   = 0;

  // RAM model with a bench-side preload port
  logic [7:0]  ram [0:524287];
  logic        pre_we = 1'b0;
  logic [18:0] pre_addr = 19'd0;
  logic [7:0]  pre_data = 8'h00;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  vga_mem_arbiter dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .xc(xc), .yc(yc),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .pix_data(pix_data), .pix_valid(pix_valid)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [18:0] a, input logic [7:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    step();
    pre_we = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    preload(19'd0, 8'h11);
    preload(19'd5, 8'h77);
    preload(19'd1000, 8'h00);
    preload(19'd3210, 8'h42);
    preload(19'd5000, 8'h00);
    preload(19'd307199, 8'hA5);
    for (int i = 0; i < 4; i++) begin
      pix_en = 1'($urandom); xc = 10'($urandom); yc = 10'($urandom);
      host_req = 1'($urandom); host_we = 1'($urandom);
      host_addr = 19'($urandom); host_wdata = 8'($urandom);
      step();
      n_checks++;
      if ({host_ack, host_rdata, mem_addr, mem_we, mem_wdata, pix_data, pix_valid} !== '0)
        $display("FAIL reset_outputs[%0d]: got ack=%b rd=%h addr=%0d we=%b wd=%h pd=%h pv=%b, want all 0",
                 i, host_ack, host_rdata, mem_addr, mem_we, mem_wdata, pix_data, pix_valid);
      else n_pass++;
    end
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    pix_en = 1'b1; xc = 10'd0; yc = 10'd0;
    reset = 1'b0;
    #1;
    n_checks++;
    if (mem_addr !== 19'd0 || mem_we !== 1'b0)
      $display("FAIL first_slot_addr: got addr=%0d we=%b, want 0/0", mem_addr, mem_we);
    else n_pass++;
    step();
    pix_en = 1'b0;
    step();
    n_checks++;
    if (pix_valid !== 1'b1 || pix_data !== 8'h11)
      $display("FAIL first_slot_pix: got pv=%b pd=%h, want 1/11", pix_valid, pix_data);
    else n_pass++;
  endtask

  task automatic test_display_corner;
    pix_en = 1'b1; xc = 10'd639; yc = 10'd479;
    #1;
    n_checks++;
    if (mem_addr !== 19'd307199 || mem_we !== 1'b0)
      $display("FAIL corner_addr: got addr=%0d we=%b, want 307199/0", mem_addr, mem_we);
    else n_pass++;
    step();
    pix_en = 1'b0;
    step();
    n_checks++;
    if (pix_valid !== 1'b1 || pix_data !== 8'hA5)
      $display("FAIL corner_pix: got pv=%b pd=%h, want 1/a5", pix_valid, pix_data);
    else n_pass++;
    // xc=640 is blanking: address parks, pixel is cleared
    pix_en = 1'b1; xc = 10'd640; yc = 10'd100;
    #1;
    n_checks++;
    if (mem_addr !== 19'd307199)
      $display("FAIL hblank_hold: got addr=%0d, want 307199", mem_addr);
    else n_pass++;
    step();
    pix_en = 1'b0;
    step();
    n_checks++;
    if (pix_valid !== 1'b0 || pix_data !== 8'h00)
      $display("FAIL hblank_pix: got pv=%b pd=%h, want 0/00", pix_valid, pix_data);
    else n_pass++;
    pix_en = 1'b1; xc = 10'd0; yc = 10'd480;
    #1;
    n_checks++;
    if (mem_addr !== 19'd307199 || mem_we !== 1'b0)
      $display("FAIL vblank_hold: got addr=%0d we=%b, want 307199/0", mem_addr, mem_we);
    else n_pass++;
    step();
    pix_en = 1'b0; xc = 10'd700; yc = 10'd0;
    step();
  endtask

  task automatic test_host_write;
    host_req = 1'b1; host_we = 1'b1; host_addr = 19'd1000; host_wdata = 8'h3C;
    #1;
    n_checks++;
    if (mem_we !== 1'b0) $display("FAIL wr_idle_we: got %b, want 0", mem_we);
    else n_pass++;
    step();
    n_checks++;
    if (mem_we !== 1'b1 || mem_addr !== 19'd1000 || mem_wdata !== 8'h3C || host_ack !== 1'b0)
      $display("FAIL wr_issue: got we=%b addr=%0d wd=%h ack=%b, want 1/1000/3c/0",
               mem_we, mem_addr, mem_wdata, host_ack);
    else n_pass++;
    step();
    n_checks++;
    if (host_ack !== 1'b1) $display("FAIL wr_ack: got %b, want 1", host_ack);
    else n_pass++;
    host_req = 1'b0;
    #1;
    n_checks++;
    if (mem_we !== 1'b0 || mem_wdata !== 8'h00)
      $display("FAIL wr_quiet: got we=%b wd=%h, want 0/00", mem_we, mem_wdata);
    else n_pass++;
    step();
    n_checks++;
    if (host_ack !== 1'b0 || ram[1000] !== 8'h3C)
      $display("FAIL wr_done: got ack=%b ram=%h, want 0/3c", host_ack, ram[1000]);
    else n_pass++;
  endtask

  task automatic test_host_stall;
    host_req = 1'b1; host_we = 1'b1; host_addr = 19'd2000; host_wdata = 8'h5A;
    step();
    pix_en = 1'b1; xc = 10'd10; yc = 10'd5;
    #1;
    n_checks++;
    if (mem_addr !== 19'd3210 || mem_we !== 1'b0)
      $display("FAIL stall_disp: got addr=%0d we=%b, want 3210/0", mem_addr, mem_we);
    else n_pass++;
    step();
    pix_en = 1'b0; xc = 10'd700; yc = 10'd0;
    #1;
    n_checks++;
    if (mem_we !== 1'b1 || mem_addr !== 19'd2000 || host_ack !== 1'b0)
      $display("FAIL stall_issue: got we=%b addr=%0d ack=%b, want 1/2000/0", mem_we, mem_addr, host_ack);
    else n_pass++;
    step();
    n_checks++;
    if (host_ack !== 1'b1 || pix_valid !== 1'b1 || pix_data !== 8'h42)
      $display("FAIL stall_ack: got ack=%b pv=%b pd=%h, want 1/1/42", host_ack, pix_valid, pix_data);
    else n_pass++;
    host_req = 1'b0;
    step();
    n_checks++;
    if (ram[2000] !== 8'h5A) $display("FAIL stall_ram: got %h, want 5a", ram[2000]);
    else n_pass++;
  endtask

  task automatic test_host_oor;
    host_req = 1'b1; host_we = 1'b1; host_addr = 19'd307200; host_wdata = 8'hFF;
    step();
    n_checks++;
    if (mem_we !== 1'b0 || mem_addr !== 19'd2000)
      $display("FAIL oor_wr_issue: got we=%b addr=%0d, want 0/2000", mem_we, mem_addr);
    else n_pass++;
    step();
    n_checks++;
    if (host_ack !== 1'b1) $display("FAIL oor_wr_ack: got %b, want 1", host_ack);
    else n_pass++;
    host_req = 1'b0;
    step();
    host_req = 1'b1; host_we = 1'b0; host_addr = 19'd400000;
    step();
    n_checks++;
    if (mem_we !== 1'b0 || mem_addr !== 19'd2000)
      $display("FAIL oor_rd_issue: got we=%b addr=%0d, want 0/2000", mem_we, mem_addr);
    else n_pass++;
`ifdef VGA_ARB_HOST_READ_EN
    step();
`endif
    step();
    n_checks++;
    if (host_ack !== 1'b1 || host_rdata !== 8'h00)
      $display("FAIL oor_rd_ack: got ack=%b rd=%h, want 1/00", host_ack, host_rdata);
    else n_pass++;
    host_req = 1'b0;
    step();
  endtask

  task automatic test_host_read;
`ifdef VGA_ARB_HOST_READ_EN
    host_req = 1'b1; host_we = 1'b0; host_addr = 19'd1000;
    step();
    n_checks++;
    if (mem_addr !== 19'd1000 || mem_we !== 1'b0)
      $display("FAIL rd_issue: got addr=%0d we=%b, want 1000/0", mem_addr, mem_we);
    else n_pass++;
    step();
    n_checks++;
    if (host_ack !== 1'b0) $display("FAIL rd_wait_ack: got %b, want 0", host_ack);
    else n_pass++;
    step();
    n_checks++;
    if (host_ack !== 1'b1 || host_rdata !== 8'h3C)
      $display("FAIL rd_ack: got ack=%b rd=%h, want 1/3c", host_ack, host_rdata);
    else n_pass++;
    host_req = 1'b0;
    step();
    host_req = 1'b1; host_we = 1'b1; host_addr = 19'd2001; host_wdata = 8'h99;
    step(); step();
    host_req = 1'b0;
    step();
    n_checks++;
    if (host_rdata !== 8'h3C) $display("FAIL rd_hold: got %h, want 3c", host_rdata);
    else n_pass++;
`else
    host_req = 1'b1; host_we = 1'b0; host_addr = 19'd5;
    step();
    n_checks++;
    if (mem_addr !== 19'd2000 || mem_we !== 1'b0)
      $display("FAIL rd_noacc: got addr=%0d we=%b, want 2000/0", mem_addr, mem_we);
    else n_pass++;
    step();
    n_checks++;
    if (host_ack !== 1'b1 || host_rdata !== 8'h00)
      $display("FAIL rd_ack: got ack=%b rd=%h, want 1/00", host_ack, host_rdata);
    else n_pass++;
    host_req = 1'b0;
    step();
    n_checks++;
    if (host_ack !== 1'b0) $display("FAIL rd_ack_pulse: got %b, want 0", host_ack);
    else n_pass++;
`endif
  endtask

  task automatic test_back_to_back;
    host_req = 1'b1; host_we = 1'b1; host_addr = 19'd3000; host_wdata = 8'h11;
    step();
    step();
    n_checks++;
    if (host_ack !== 1'b1) $display("FAIL b2b_ack1: got %b, want 1", host_ack);
    else n_pass++;
    host_addr = 19'd3001; host_wdata = 8'h22;
    step();
    n_checks++;
    if (host_ack !== 1'b0 || mem_we !== 1'b0)
      $display("FAIL b2b_gap: got ack=%b we=%b, want 0/0", host_ack, mem_we);
    else n_pass++;
    step();
    n_checks++;
    if (mem_we !== 1'b1 || mem_addr !== 19'd3001 || mem_wdata !== 8'h22)
      $display("FAIL b2b_issue2: got we=%b addr=%0d wd=%h, want 1/3001/22", mem_we, mem_addr, mem_wdata);
    else n_pass++;
    step();
    host_req = 1'b0;
    n_checks++;
    if (host_ack !== 1'b1 || ram[3000] !== 8'h11 || ram[3001] !== 8'h22)
      $display("FAIL b2b_done: got ack=%b r0=%h r1=%h, want 1/11/22", host_ack, ram[3000], ram[3001]);
    else n_pass++;
    step();
  endtask

  task automatic test_reset_abort;
    host_req = 1'b1; host_we = 1'b1; host_addr = 19'd5000; host_wdata = 8'h99;
    step();
    pix_en = 1'b1; xc = 10'd0; yc = 10'd0;
    #1;
    reset = 1'b1;
    #1;
    n_checks++;
    if (mem_we !== 1'b0 || mem_addr !== 19'd0 || host_ack !== 1'b0)
      $display("FAIL abort_in_reset: got we=%b addr=%0d ack=%b, want 0/0/0", mem_we, mem_addr, host_ack);
    else n_pass++;
    step();
    reset = 1'b0; host_req = 1'b0; pix_en = 1'b0; xc = 10'd700;
    step();
    step();
    n_checks++;
    if (host_ack !== 1'b0 || ram[5000] !== 8'h00)
      $display("FAIL abort_discard: got ack=%b ram=%h, want 0/00", host_ack, ram[5000]);
    else n_pass++;
    pix_en = 1'b1; xc = 10'd639; yc = 10'd479;
    step();
    pix_en = 1'b0; xc = 10'd700; yc = 10'd0;
    step();
    n_checks++;
    if (pix_valid !== 1'b1 || pix_data !== 8'hA5)
      $display("FAIL abort_next_slot: got pv=%b pd=%h, want 1/a5", pix_valid, pix_data);
    else n_pass++;
  endtask

  initial begin
    reset = 1'b1; pix_en = 1'b0; xc = '0; yc = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    test_reset();
    test_display_corner();
    test_host_write();
    test_host_stall();
    test_host_oor();
    test_host_read();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
